apb_uart_regs: RTL
==================

APB_UART_REGS -- requirements
Module: apb_uart_regs

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the UART character width.
REQ-002 SHALL have parameter TIMEOUT, default 255, the maximum wait cycles for a stalled DATA write.
REQ-003 SHALL have clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have psel, penable, pwrite, input, 1 each, APB3 control.
REQ-006 SHALL have paddr, input, 5, byte address; bits [1:0] are ignored.
REQ-007 SHALL have pwdata, input, 32, write data; prdata, output, 32, read data.
REQ-008 SHALL have pready and pslverr, output, 1 each, APB completion and error.
REQ-009 SHALL have tx_data_out (DATA_WIDTH), output, and tx_valid_out (1), output; tx_ready_in (1), input: stream to the uart_fifo TX side.
REQ-010 SHALL have rx_data_in (DATA_WIDTH), input, and rx_valid_in (1), input; rx_ready_out (1), output: stream from the uart_fifo RX side.
REQ-011 SHALL have prescale, output, 16, the uart_fifo baud divider; irq, output, 1, level interrupt.

Function
REQ-012 SHALL decode offsets 0x00 DATA, 0x04 STATUS (RO), 0x08 CTRL (prescale[15:0], RW), 0x0C IRQ_EN ([0] rx_avail, [1] tx_empty, RW), 0x10 ERR (W1C); other offsets SHALL read 0, ignore writes, and set pslverr=0.
REQ-013 SHALL complete every access, except a stalled DATA write, in the first PENABLE cycle (pready=1, zero wait states).
REQ-014 SHALL hold one TX character in a holding register; tx_valid_out=1 while it is full; it SHALL clear on a cycle with tx_valid_out&&tx_ready_in.
REQ-015 On a DATA write with holding empty: SHALL load pwdata[DATA_WIDTH-1:0] and complete; tx_valid_out SHALL rise the next cycle.
REQ-016 On a DATA write with holding full: SHALL drive pready=0 and count wait cycles; SHALL complete on the cycle the holding becomes empty (load and release in the same edge).
REQ-017 If the wait count reaches TIMEOUT: SHALL complete with pready=1, pslverr=1, drop the data, and set ERR[1] tx_timeout.
REQ-018 On a DATA read with rx_valid_in=1: prdata={0,rx_data_in}; SHALL pulse rx_ready_out for exactly the completing cycle.
REQ-019 On a DATA read with rx_valid_in=0: prdata=0, pslverr=1, set ERR[0] rx_underflow, no rx_ready_out.
REQ-020 STATUS SHALL be [0] holding empty, [1] rx_valid_in, [2] tx_valid_out, [3] ERR!=0; other bits 0.
REQ-021 ERR bits SHALL be sticky; writing 1 clears; a same-cycle set and clear SHALL leave the bit set.
REQ-022 irq SHALL be registered: (IRQ_EN[0]&rx_valid_in)|(IRQ_EN[1]&holding empty)|(ERR!=0), 1-cycle latency.
REQ-023 pslverr and prdata SHALL be 0 whenever pready=0 or no access is in progress.
REQ-024 A setup phase (psel&&!penable) SHALL cause no side effect; side effects SHALL occur only on the completing cycle.
REQ-025 prescale SHALL equal CTRL[15:0]; a CTRL write SHALL take effect on the next cycle.

Reset
REQ-026 rst SHALL set: holding empty, tx_valid_out=0, tx_data_out=0, rx_ready_out=0, prescale=54, IRQ_EN=0, ERR=0, wait counter=0, irq=0, prdata=0, pslverr=0.
REQ-027 rst asserted during a stalled write SHALL abandon it; pready SHALL return to 1 after reset.

Structure
REQ-028 Register offsets, the reset prescale value 54, STATUS/ERR bit indices, and the default TIMEOUT SHALL live in shared package uart_apb_pkg.
REQ-029 The block SHALL be one flat module with no sub-module; top-level integration instantiates it beside uart_fifo.

Verification
REQ-030 After reset, read CTRL -> 0x36; read STATUS -> 0x1; irq=0.
REQ-031 Write DATA 0x48 with tx_ready_in=1 -> zero wait states; tx_valid_out=1 with tx_data_out=0x48 for exactly one cycle.
REQ-032 tx_ready_in=0; write 0x45, then 0x4C -> the second write stalls; raise tx_ready_in after 10 cycles -> completes on that cycle with pslverr=0; 0x45 then 0x4C appear.
REQ-033 tx_ready_in held 0; second write -> pready=0 for 255 cycles, then pslverr=1; ERR=0x2; irq=1; write ERR=0x2 -> irq falls.
REQ-034 rx_valid_in=1, rx_data_in=0x4F; read DATA -> prdata=0x4F, one rx_ready_out pulse; repeat with rx_valid_in=0 -> pslverr=1, ERR[0]=1.
REQ-035 Reset asserted mid-stall -> pready=1, tx_valid_out=0, and all registers at reset values the next cycle.

Source files
------------

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB UART register block.
// Holds register byte offsets, the reset baud divider, STATUS/ERR/IRQ_EN bit
// indices and the default DATA-write stall limit.
package uart_apb_pkg;

  localparam logic [4:0] ADDR_DATA   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h04;
  localparam logic [4:0] ADDR_CTRL   = 5'h08;
  localparam logic [4:0] ADDR_IRQ_EN = 5'h0C;
  localparam logic [4:0] ADDR_ERR    = 5'h10;

  localparam logic [15:0] PRESCALE_RST = 16'd54;

  localparam int unsigned STAT_TX_EMPTY = 0;
  localparam int unsigned STAT_RX_VALID = 1;
  localparam int unsigned STAT_TX_VALID = 2;
  localparam int unsigned STAT_ERR      = 3;

  localparam int unsigned ERR_RX_UNDERFLOW = 0;
  localparam int unsigned ERR_TX_TIMEOUT   = 1;

  localparam int unsigned IRQ_RX_AVAIL = 0;
  localparam int unsigned IRQ_TX_EMPTY = 1;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // Word index of a byte address (bits [1:0] carry no meaning).
  function automatic logic [2:0] word_index(input logic [4:0] addr);
    return addr[4:2];
  endfunction

endpackage

// File: rtl/apb_uart_regs.sv
// APB3 register front-end for a UART FIFO core.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr - APB3 slave
//   tx_data_out/tx_valid_out/tx_ready_in - one-character TX holding stream
//   rx_data_in/rx_valid_in/rx_ready_out  - RX stream consumed by DATA reads
//   prescale                  - baud divider (CTRL register)
//   irq                       - registered level interrupt
module apb_uart_regs
  import uart_apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [4:0]            paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] tx_data_out,
  output logic                  tx_valid_out,
  input  logic                  tx_ready_in,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rx_valid_in,
  output logic                  rx_ready_out,
  output logic [15:0]           prescale,
  output logic                  irq
);

  localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_valid;
  logic [WAIT_W-1:0]     r_wait;
  logic [15:0]           r_prescale;
  logic [1:0]            r_irq_en;
  logic [1:0]            r_err;
  logic                  r_irq;

  logic       w_access;
  logic [2:0] w_idx;
  logic       w_data_wr;
  logic       w_data_rd;
  logic       w_tx_release;
  logic       w_tx_free;
  logic       w_timeout;
  logic       w_stall;
  logic       w_load;
  logic       w_tx_to;
  logic       w_rx_under;
  logic       w_reg_wr;
  logic [1:0] w_err_clr;
  logic [1:0] w_err_set;
  logic       w_unused;

  assign w_unused = ^{pwdata, paddr[1:0]};

  always_comb begin
    // Reset masks the bus so an access in flight has no effect and no stall.
    w_access     = psel && penable && !rst;
    w_idx        = word_index(paddr);
    w_data_wr    = w_access && pwrite && (w_idx == word_index(ADDR_DATA));
    w_data_rd    = w_access && !pwrite && (w_idx == word_index(ADDR_DATA));
    w_tx_release = r_tx_valid && tx_ready_in;
    // Holding is writable if empty now or being drained on this edge.
    w_tx_free    = !r_tx_valid || tx_ready_in;
    w_timeout    = (r_wait >= WAIT_W'(TIMEOUT));
    w_stall      = w_data_wr && !w_tx_free && !w_timeout;
    w_load       = w_data_wr && w_tx_free;
    w_tx_to      = w_data_wr && !w_tx_free && w_timeout;
    w_rx_under   = w_data_rd && !rx_valid_in;
    w_reg_wr     = w_access && pwrite;
    w_err_clr    = (w_reg_wr && (w_idx == word_index(ADDR_ERR))) ? pwdata[1:0] : '0;
    w_err_set    = '0;
    w_err_set[ERR_TX_TIMEOUT]   = w_tx_to;
    w_err_set[ERR_RX_UNDERFLOW] = w_rx_under;
  end

  always_comb begin
    prdata = '0;
    if (w_access && !pwrite) begin
      case (w_idx)
        word_index(ADDR_DATA): begin
          if (rx_valid_in) prdata[DATA_WIDTH-1:0] = rx_data_in;
        end
        word_index(ADDR_STATUS): begin
          prdata[STAT_TX_EMPTY] = !r_tx_valid;
          prdata[STAT_RX_VALID] = rx_valid_in;
          prdata[STAT_TX_VALID] = r_tx_valid;
          prdata[STAT_ERR]      = |r_err;
        end
        word_index(ADDR_CTRL):   prdata[15:0] = r_prescale;
        word_index(ADDR_IRQ_EN): prdata[1:0]  = r_irq_en;
        word_index(ADDR_ERR):    prdata[1:0]  = r_err;
        default: ;
      endcase
    end
  end

  assign pready       = !w_stall;
  assign pslverr      = w_tx_to || w_rx_under;
  assign rx_ready_out = w_data_rd && rx_valid_in;
  assign tx_data_out  = r_tx_data;
  assign tx_valid_out = r_tx_valid;
  assign prescale     = r_prescale;
  assign irq          = r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_wait     <= '0;
      r_prescale <= PRESCALE_RST;
      r_irq_en   <= '0;
      r_err      <= '0;
      r_irq      <= 1'b0;
    end else begin
      // Load wins over release: a drain and a refill on the same edge keep
      // the holding register full with the new character.
      if (w_load) begin
        r_tx_data  <= pwdata[DATA_WIDTH-1:0];
        r_tx_valid <= 1'b1;
      end else if (w_tx_release) begin
        r_tx_valid <= 1'b0;
      end
      r_wait <= w_stall ? r_wait + WAIT_W'(1) : '0;
      if (w_reg_wr && (w_idx == word_index(ADDR_CTRL)))   r_prescale <= pwdata[15:0];
      if (w_reg_wr && (w_idx == word_index(ADDR_IRQ_EN))) r_irq_en   <= pwdata[1:0];
      // Set has priority over write-one-to-clear.
      r_err <= (r_err & ~w_err_clr) | w_err_set;
      r_irq <= (r_irq_en[IRQ_RX_AVAIL] && rx_valid_in) ||
               (r_irq_en[IRQ_TX_EMPTY] && !r_tx_valid) ||
               (|r_err);
    end
  end

endmodule
